// File: rtl/mcyc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback.
// Define MCYC_CTRL_MISALIGN_TRAP_EN to trap on misaligned targets/accesses and bad opcodes.
module mcyc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              addr_sel,
  output logic [3:0]        alu_ctrl,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic [31:0]       imm,
  output logic              imm_sel,
  output logic [4:0]        regA_sel,
  output logic [4:0]        regB_sel,
  output logic [4:0]        regW_sel,
  output logic              reg_wen,
  output logic [1:0]        wb_sel,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              instret,
  output logic              trap
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] PcInit = RESET_PC[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;

`ifdef MCYC_CTRL_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
  assign trap = (state_q == TRAP);
`else
  localparam bit TrapEn = 1'b0;
  assign trap = 1'b0;
`endif

  logic [6:0] opc;
  logic [2:0] f3;
  logic is_op, is_opimm, is_lui, is_auipc, is_ld, is_st;
  logic is_br, is_jal, is_jalr, is_alu, illegal, bad_f3;

  assign opc      = ir_q[6:0];
  assign f3       = ir_q[14:12];
  assign is_op    = (opc == 7'b0110011);
  assign is_opimm = (opc == 7'b0010011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_alu   = is_op | is_opimm | is_lui | is_auipc;
  assign illegal  = ~(is_alu | is_ld | is_st | is_br | is_jal | is_jalr);

  assign bad_f3 = (is_br & (f3[2:1] == 2'b01))
                | (is_ld & ((f3 == 3'b011) | (f3[2:1] == 2'b11)))
                | (is_st & ((f3 == 3'b011) | f3[2]))
                | (is_jalr & (f3 != 3'b000));

  assign regA_sel = is_lui ? 5'd0 : ir_q[19:15];
  assign regB_sel = ir_q[24:20];
  assign regW_sel = ir_q[11:7];
  assign imm_sel  = is_opimm | is_ld | is_st | is_jalr | is_lui;

  always_comb begin
    imm = 32'd0;
    unique case (1'b1)
      is_opimm, is_ld, is_jalr:
        imm = {{20{ir_q[31]}}, ir_q[31:20]};
      is_st:
        imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      is_br:
        imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
               ir_q[30:25], ir_q[11:8], 1'b0};
      is_lui, is_auipc:
        imm = {ir_q[31:12], 12'd0};
      is_jal:
        imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
               ir_q[20], ir_q[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  always_comb begin
    alu_ctrl = 4'b0000;
    if (is_op)
      alu_ctrl = {ir_q[30], f3};
    else if (is_opimm)
      alu_ctrl = (f3[1:0] == 2'b01) ? {ir_q[30], f3} : {1'b0, f3};
    else if (is_br)
      alu_ctrl = !f3[2] ? 4'b1000 : (f3[1] ? 4'b0011 : 4'b0010);
  end

  assign wb_sel = is_ld              ? 2'd1 :
                  (is_jal | is_jalr) ? 2'd2 :
                  is_auipc           ? 2'd3 : 2'd0;

  logic [ADDR_W-1:0] pc_inc, pc_imm, jmp_tgt;
  logic [31:0]       jalr_tgt;
  logic              taken, ls_mis;

  assign pc_inc   = pc_q + ADDR_W'(4);
  assign pc_imm   = pc_q + imm[ADDR_W-1:0];
  assign jalr_tgt = {alu_result[31:1], 1'b0};
  assign jmp_tgt  = is_jal ? pc_imm : jalr_tgt[ADDR_W-1:0];
  // Branch polarity: BEQ/BGE/BGEU take on zero, the others on non-zero.
  assign taken    = alu_zero ^ (f3[0] ^ f3[2]);
  assign ls_mis   = ((f3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00))
                  | ((f3[1:0] == 2'b01) & alu_result[0]);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    mem_size = 3'b010;
    reg_wen  = 1'b0;
    instret  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (TrapEn && illegal) begin
          state_d = TRAP;
        end else if (illegal || bad_f3) begin
          pc_d    = pc_inc;
          instret = 1'b1;
          state_d = FETCH;
        end else begin
          unique case (1'b1)
            is_alu: state_d = WB;
            is_ld, is_st:
              state_d = (TrapEn && ls_mis) ? TRAP : MEM;
            is_br: begin
              if (TrapEn && taken && (pc_imm[1:0] != 2'b00)) begin
                state_d = TRAP;
              end else begin
                pc_d    = taken ? pc_imm : pc_inc;
                instret = 1'b1;
                state_d = FETCH;
              end
            end
            is_jal, is_jalr: begin
              if (TrapEn && (jmp_tgt[1:0] != 2'b00)) begin
                state_d = TRAP;
              end else begin
                reg_wen = 1'b1;
                pc_d    = jmp_tgt;
                instret = 1'b1;
                state_d = FETCH;
              end
            end
            default: state_d = FETCH;
          endcase
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_size = f3;
        mem_we   = is_st;
        if (mem_ready) begin
          if (is_st) begin
            pc_d    = pc_inc;
            instret = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_wen = 1'b1;
        pc_d    = pc_inc;
        instret = 1'b1;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // An access in flight when reset hits is dropped without side effects.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      reg_wen = 1'b0;
      instret = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PcInit;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign mem_addr = addr_sel ? alu_result[ADDR_W-1:0] : pc_q;
  assign pc       = pc_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Scoreboard bench for mcyc_ctrl: instruction vectors with expected retires.
// PC starts near the top of the space so fetches wrap through zero.
module tb_mcyc_ctrl;
  localparam logic [31:0] RP = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, addr_sel;
  logic [2:0]  mem_size, state;
  logic [31:0] mem_rdata, mem_addr, alu_result, imm, pc;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, imm_sel, reg_wen, instret, trap;
  logic [4:0]  regA_sel, regB_sel, regW_sel;
  logic [1:0]  wb_sel;

  always #5 clk = ~clk;

  mcyc_ctrl #(.RESET_PC(RP), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .addr_sel(addr_sel),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .imm(imm), .imm_sel(imm_sel),
    .regA_sel(regA_sel), .regB_sel(regB_sel),
    .regW_sel(regW_sel), .reg_wen(reg_wen), .wb_sel(wb_sel),
    .pc(pc), .state(state), .instret(instret), .trap(trap)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] ares;
    logic        z;
    int          fw;
    int          mw;
    logic [1:0]  wb;
    logic [31:0] pcn;
    int          cyc;
    int          wen;
    int          we;
    logic [31:0] imm;
    bit          ichk;
    int          alu;
    bit          trp;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  wb;
  } ret_t;

  ret_t        sb[$];
  ret_t        mon_r;
  logic [31:0] model_pc;

  always @(negedge clk) begin
    #2;
    if (!rst && instret === 1'b1) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_r = sb.pop_front();
        check("ret_pc", pc, mon_r.pc);
        if (reg_wen) check("ret_wb", 32'(wb_sel), 32'(mon_r.wb));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_pc", pc, RP);
    check("rst_trap", 32'(trap), 0);
    check("rst_instret", 32'(instret), 0);
    check("rst_wen", 32'(reg_wen), 0);
    check("rst_we", 32'(mem_we), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req", 32'(mem_req), 1);
    check("post_rst_addr", mem_addr, RP);
    model_pc = RP;
    sb.delete();
  endtask

  task automatic run(input int idx, input vec_t v);
    int   cyc = 0, fc = 0, mc = 0, wen = 0, we = 0;
    bit   done = 0;
    logic [2:0] st;
    ret_t r;
    string t;
    t = $sformatf("v%0d", idx);
    if (!v.trp) begin
      r.pc = model_pc;
      r.wb = v.wb;
      sb.push_back(r);
    end
    alu_result = v.ares;
    alu_zero = v.z;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      st = state;
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      if (st == 3'd0) begin
        if (fc >= v.fw) begin
          mem_ready = 1'b1;
          mem_rdata = v.ins;
        end
        fc++;
      end
      if (st == 3'd3) begin
        if (mc >= v.mw) mem_ready = 1'b1;
        mc++;
      end
      #1;
      if (st == 3'd0) begin
        check({t, "_freq"}, 32'(mem_req), 1);
        check({t, "_faddr"}, mem_addr, model_pc);
      end
      if (st == 3'd1) begin
        check({t, "_rd"}, 32'(regW_sel), 32'(v.ins[11:7]));
        check({t, "_rs2"}, 32'(regB_sel), 32'(v.ins[24:20]));
      end
      if (st == 3'd2) begin
        if (v.ichk) check({t, "_imm"}, imm, v.imm);
        if (v.alu >= 0) check({t, "_alu"}, 32'(alu_ctrl), v.alu);
        if (v.ins[6:0] == 7'h37) begin
          check({t, "_lui_ra"}, 32'(regA_sel), 0);
          check({t, "_lui_isel"}, 32'(imm_sel), 1);
        end
      end
      if (st == 3'd3) begin
        check({t, "_mreq"}, 32'(mem_req), 1);
        check({t, "_maddr"}, mem_addr, v.ares);
        check({t, "_msize"}, 32'(mem_size), 32'(v.ins[14:12]));
        check({t, "_asel"}, 32'(addr_sel), 1);
      end
      if (reg_wen) wen++;
      if (mem_we) we++;
      if (instret || st == 3'd5) done = 1;
    end
    check({t, "_done"}, 32'(done), 1);
    @(posedge clk);
    #1;
    model_pc = RP + v.pcn;
    check({t, "_pc"}, pc, model_pc);
    check({t, "_cyc"}, cyc, v.cyc);
    check({t, "_fcyc"}, fc, v.fw + 1);
    check({t, "_wen"}, wen, v.wen);
    check({t, "_we"}, we, v.we);
    check({t, "_trap"}, 32'(trap), 32'(v.trp));
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0001_2283;
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;

  initial begin
    vec_t v;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    alu_result = 32'h0;
    alu_zero = 1'b0;
    model_pc = RP;
    do_reset();
    run(0, '{ADDI, 5, 0, 0, 0, 0, 32'h04, 4, 1, 0, 5, 1, 0, 0});
    run(1, '{ADDI, 5, 0, 3, 0, 0, 32'h08, 7, 1, 0, 5, 1, 0, 0});
    run(2, '{32'h4020_81B3, 0, 0, 0, 0, 0, 32'h0C, 4, 1, 0, 0, 0, 8, 0});
    run(3, '{32'h4030_D093, 0, 0, 0, 0, 0, 32'h10, 4, 1, 0,
             32'h403, 1, 13, 0});
    run(4, '{BEQ, 0, 1, 0, 0, 0, 32'h08, 3, 0, 0,
             32'hFFFF_FFF8, 1, 8, 0});
    run(5, '{LW, 32'h100, 0, 0, 2, 1, 32'h0C, 7, 1, 0, 0, 1, 0, 0});
    run(6, '{32'h0051_2223, 32'h104, 0, 0, 1, 0, 32'h10, 5, 0, 2,
             4, 1, 0, 0});
    run(7, '{32'h0080_00EF, 0, 0, 0, 0, 2, 32'h18, 3, 1, 0, 8, 1, -1, 0});
    run(8, '{32'h0000_8067, RP + 32'h21, 0, 0, 0, 2, 32'h20, 3, 1, 0,
             0, 1, 0, 0});
    run(9, '{32'hC000_C093, 0, 0, 0, 0, 0, 32'h24, 4, 1, 0,
             32'hFFFF_FC00, 1, 4, 0});
    run(10, '{32'hFE00_2CE3, 0, 1, 0, 0, 0, 32'h28, 3, 0, 0,
              32'hFFFF_FFF8, 1, -1, 0});
    run(11, '{32'h1234_51B7, 0, 0, 0, 0, 0, 32'h2C, 4, 1, 0,
              32'h1234_5000, 1, 0, 0});
    run(12, '{32'h0000_1217, 0, 0, 0, 0, 3, 32'h30, 4, 1, 0,
              32'h1000, 1, -1, 0});
`ifdef MCYC_CTRL_MISALIGN_TRAP_EN
    run(13, '{LW, 32'h102, 0, 0, 0, 1, 32'h30, 4, 0, 0, 0, 1, 0, 1});
`else
    run(13, '{LW, 32'h102, 0, 0, 0, 1, 32'h34, 5, 1, 0, 0, 1, 0, 0});
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = '{ADDI, 5, 0, 0, 0, 0, 32'(4 * (i + 1)), 4, 1, 0, 5, 1, 0, 0};
      run(20 + i, v);
    end
    run(24, '{BEQ, 0, 0, 0, 0, 0, 32'h14, 3, 0, 0,
              32'hFFFF_FFF8, 1, 8, 0});
    // Store abandoned by reset while waiting in MEM.
    mem_rdata = 32'h0051_2223;
    mem_ready = 1'b1;
    alu_result = 32'h104;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state == 3'd3) break;
    end
    mem_ready = 1'b0;
    check("abort_in_mem", 32'(state), 3);
    rst = 1'b1;
    #1;
    check("abort_we", 32'(mem_we), 0);
    check("abort_instret", 32'(instret), 0);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
